// File: rtl/fme_ref_loader_pkg.sv
// Shared constants, FSM state type and MV clip helper for the FME reference
// patch loader and its pixel aligner.
package fme_ref_loader_pkg;

    localparam int BIT_DEPTH    = 8;
    localparam int MB_WIDTH     = 16;
    localparam int PAD          = 4;
    localparam int REF_W        = MB_WIDTH + 2 * PAD;
    localparam int WIN_COLS     = 5;
    localparam int WIN_ROWS     = 3;
    localparam int SEGS_PER_ROW = 3;

    localparam int SEG_BITS = MB_WIDTH * BIT_DEPTH;
    localparam int REF_BITS = REF_W * BIT_DEPTH;
    localparam int ROW_BITS = SEGS_PER_ROW * SEG_BITS;

    localparam int MVX_MIN = -28;
    localparam int MVX_MAX = 19;
    localparam int MVY_MIN = -12;
    localparam int MVY_MAX = 12;

    // Position of the current MB inside the 5x3 MB search window, in pixels.
    localparam int CUR_WX = 32;
    localparam int CUR_WY = 16;

    localparam logic [1:0] K_LAST = 2'(SEGS_PER_ROW - 1);
    localparam logic [4:0] R_LAST = 5'(REF_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_REQ   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fsm_state_e;

    function automatic logic signed [7:0] clip_s8(input logic signed [7:0] v,
                                                  input int lo, input int hi);
        if (int'(v) < lo) begin
            return 8'(lo);
        end else if (int'(v) > hi) begin
            return 8'(hi);
        end
        return v;
    endfunction

endpackage

// File: rtl/fme_ref_loader_if.sv
// Fetch-stage request/response bus and reference-buffer write port of the loader.
interface fme_ref_loader_if;
    import fme_ref_loader_pkg::*;

    // fme_ld_en_o is a request strobe without backpressure: every cycle it is
    // high one segment is requested, and fme_ld_valid_i/fme_lddata_i must answer
    // it exactly one cycle later. ref_wr_en_o qualifies addr/data for one cycle.
    logic                fme_ld_start_o;
    logic                fme_ld_en_o;
    logic                fme_ld_done_o;
    logic [7:0]          fme_mb_x_o;
    logic [7:0]          fme_mb_y_o;
    logic [2:0]          fme_sw_xx_o;
    logic [2:0]          fme_sw_yy_o;
    logic [3:0]          fme_sw_zz_o;
    logic [SEG_BITS-1:0] fme_lddata_i;
    logic                fme_ld_valid_i;
    logic                ref_wr_en_o;
    logic [4:0]          ref_wr_addr_o;
    logic [REF_BITS-1:0] ref_wr_data_o;
    fsm_state_e          dbg_state;

    modport master (
        output fme_ld_start_o, fme_ld_en_o, fme_ld_done_o,
        output fme_mb_x_o, fme_mb_y_o,
        output fme_sw_xx_o, fme_sw_yy_o, fme_sw_zz_o,
        input  fme_lddata_i, fme_ld_valid_i,
        output ref_wr_en_o, ref_wr_addr_o, ref_wr_data_o,
        output dbg_state
    );

    modport slave (
        input  fme_ld_start_o, fme_ld_en_o, fme_ld_done_o,
        input  fme_mb_x_o, fme_mb_y_o,
        input  fme_sw_xx_o, fme_sw_yy_o, fme_sw_zz_o,
        output fme_lddata_i, fme_ld_valid_i,
        input  ref_wr_en_o, ref_wr_addr_o, ref_wr_data_o,
        input  dbg_state
    );

endinterface

// File: rtl/fme_ref_align.sv
// Picks the 24-pixel reference row out of a 48-pixel row made of two stored
// segments plus the segment arriving this cycle.
module fme_ref_align
    import fme_ref_loader_pkg::*;
(
    input  logic [2*SEG_BITS-1:0] row_i,
    input  logic [SEG_BITS-1:0]   seg_i,
    input  logic [3:0]            off_i,
    output logic [REF_BITS-1:0]   pix_o
);

    logic [ROW_BITS-1:0] row48;

    always_comb begin
        row48 = {seg_i, row_i};
        pix_o = '0;
        // off never exceeds 15, so off+23 always lands inside the 48 pixels.
        for (int i = 0; i < REF_W; i++) begin
            pix_o[i*BIT_DEPTH +: BIT_DEPTH] = row48[(int'(off_i) + i)*BIT_DEPTH +: BIT_DEPTH];
        end
    end

endmodule

// File: rtl/fme_ref_loader.sv
// Per-MB search-window load sequencer: issues 24 rows x 3 segment requests
// around the clipped integer MV and writes aligned 24-pixel rows to the FME buffer.
module fme_ref_loader
    import fme_ref_loader_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [7:0]       mb_x_i,
    input  logic [7:0]       mb_y_i,
    input  logic [6:0]       mv_x_i,
    input  logic [5:0]       mv_y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             mv_clip_o,
    fme_ref_loader_if.master fme
);

    fsm_state_e            state_q, state_d;
    logic [4:0]            r_q, r_d;
    logic [1:0]            k_q, k_d;
    logic                  tag_vld_q, tag_vld_d;
    logic [1:0]            tag_k_q, tag_k_d;
    logic [4:0]            tag_r_q, tag_r_d;
    logic [7:0]            mb_x_q, mb_x_d;
    logic [7:0]            mb_y_q, mb_y_d;
    logic [1:0]            c0_q, c0_d;
    logic [3:0]            off_q, off_d;
    logic [4:0]            wy0_q, wy0_d;
    logic                  clip_q, clip_d;
    logic [2*SEG_BITS-1:0] row_q, row_d;

    logic signed [7:0] mvx_ext, mvy_ext, mvx_c, mvy_c;
    logic [5:0]        wx0;
    logic [4:0]        wy0;
    logic              clip_any;
    logic              ld_start, ld_en, busy, done;
    logic [5:0]        line_sum;
    logic [2:0]        xx_raw;
    logic              cap, wr_en;
    logic [REF_BITS-1:0] aligned;

    always_comb begin
        mvx_ext  = signed'({mv_x_i[6], mv_x_i});
        mvy_ext  = signed'({{2{mv_y_i[5]}}, mv_y_i});
        mvx_c    = clip_s8(mvx_ext, MVX_MIN, MVX_MAX);
        mvy_c    = clip_s8(mvy_ext, MVY_MIN, MVY_MAX);
        clip_any = (mvx_c != mvx_ext) || (mvy_c != mvy_ext);
        // Patch origin in window pixels: current MB position minus the border.
        wx0      = 6'(mvx_c + 8'(CUR_WX - PAD));
        wy0      = 5'(mvy_c + 8'(CUR_WY - PAD));
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        k_d      = k_q;
        mb_x_d   = mb_x_q;
        mb_y_d   = mb_y_q;
        c0_d     = c0_q;
        off_d    = off_q;
        wy0_d    = wy0_q;
        clip_d   = clip_q;
        ld_start = 1'b0;
        ld_en    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_i) begin
                    mb_x_d  = mb_x_i;
                    mb_y_d  = mb_y_i;
                    c0_d    = wx0[5:4];
                    off_d   = wx0[3:0];
                    wy0_d   = wy0;
                    clip_d  = clip_any;
                    r_d     = '0;
                    k_d     = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                ld_start = 1'b1;
                state_d  = ST_REQ;
            end
            ST_REQ: begin
                ld_en = 1'b1;
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (r_q == R_LAST) begin
                        r_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        r_d = r_q + 5'd1;
                    end
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            ST_DRAIN: begin
                // The final segment answers in the cycle after the last request.
                if (tag_vld_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tag_vld_d = ld_en;
        tag_k_d   = k_q;
        tag_r_d   = r_q;
        line_sum  = 6'(wy0_q) + 6'(r_q);
        xx_raw    = 3'(c0_q) + 3'(k_q) - 3'd1;

        cap   = tag_vld_q && fme.fme_ld_valid_i;
        wr_en = cap && (tag_k_q == K_LAST);
        row_d = row_q;
        // Slots 0 and 1 are stored; slot 2 is consumed straight off the bus.
        if (cap && !wr_en) begin
            row_d[int'(tag_k_q[0])*SEG_BITS +: SEG_BITS] = fme.fme_lddata_i;
        end
    end

    fme_ref_align u_align (
        .row_i (row_q),
        .seg_i (fme.fme_lddata_i),
        .off_i (off_q),
        .pix_o (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            r_q       <= '0;
            k_q       <= '0;
            tag_vld_q <= 1'b0;
            tag_k_q   <= '0;
            tag_r_q   <= '0;
            mb_x_q    <= '0;
            mb_y_q    <= '0;
            c0_q      <= '0;
            off_q     <= '0;
            wy0_q     <= '0;
            clip_q    <= 1'b0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            k_q       <= k_d;
            tag_vld_q <= tag_vld_d;
            tag_k_q   <= tag_k_d;
            tag_r_q   <= tag_r_d;
            mb_x_q    <= mb_x_d;
            mb_y_q    <= mb_y_d;
            c0_q      <= c0_d;
            off_q     <= off_d;
            wy0_q     <= wy0_d;
            clip_q    <= clip_d;
            row_q     <= row_d;
        end
    end

    assign busy_o    = busy;
    assign done_o    = done;
    assign mv_clip_o = clip_q;

    assign fme.fme_ld_start_o = ld_start;
    assign fme.fme_ld_en_o    = ld_en;
    assign fme.fme_ld_done_o  = done;
    assign fme.fme_mb_x_o     = mb_x_q;
    assign fme.fme_mb_y_o     = mb_y_q;
    assign fme.fme_sw_xx_o    = ld_en ? xx_raw : 3'd0;
    assign fme.fme_sw_yy_o    = ld_en ? {1'b0, line_sum[5:4]} : 3'd0;
    assign fme.fme_sw_zz_o    = ld_en ? line_sum[3:0] : 4'd0;
    assign fme.ref_wr_en_o    = wr_en;
    assign fme.ref_wr_addr_o  = wr_en ? tag_r_q : 5'd0;
    assign fme.ref_wr_data_o  = wr_en ? aligned : '0;
    assign fme.dbg_state      = state_q;

endmodule

// File: tb/tb_fme_ref_loader.sv
// Directed bench: a fetch-stage responder serves window pixels from a hash,
// a monitor checks requests, row writes and done timing against expected queues.
module tb_fme_ref_loader;
    import fme_ref_loader_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] mb_x_i = '0;
    logic [7:0] mb_y_i = '0;
    logic [6:0] mv_x_i = '0;
    logic [5:0] mv_y_i = '0;
    logic       busy_o, done_o, mv_clip_o;

    fme_ref_loader_if fme();

    fme_ref_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .mb_x_i    (mb_x_i),
        .mb_y_i    (mb_y_i),
        .mv_x_i    (mv_x_i),
        .mv_y_i    (mv_y_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .mv_clip_o (mv_clip_o),
        .fme       (fme)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic [6:0] mvx;
        logic [5:0] mvy;
        int         c0;
        int         off;
        int         wy0;
        logic       clip;
        logic [2:0] fxx;
        logic [2:0] fyy;
        logic [3:0] fzz;
        int         stray;
        bit         noise;
    } vec_t;

    vec_t vecs[5];

    logic [9:0]          exp_req_q[$];
    logic [REF_BITS+4:0] exp_wr_q[$];
    logic [31:0]         exp_done_q[$];

    int n_checks = 0;
    int n_err    = 0;
    bit noise_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got unexpected event expected none", name);
    endtask

    function automatic logic [7:0] pix(input int wx, input int wy);
        return 8'((wx * 37 + wy * 11 + wx * wy) ^ 90);
    endfunction

    function automatic logic [SEG_BITS-1:0] seg_of(input logic [2:0] xx, input logic [2:0] yy,
                                                   input logic [3:0] zz);
        int bx;
        int wy;
        bx = (int'($signed(xx)) + 1) * MB_WIDTH;
        wy = int'(yy) * MB_WIDTH + int'(zz);
        seg_of = '0;
        for (int i = 0; i < MB_WIDTH; i++) begin
            seg_of[i*BIT_DEPTH +: BIT_DEPTH] = pix(bx + i, wy);
        end
    endfunction

    function automatic logic [REF_BITS-1:0] exp_row(input int wx0, input int wy);
        exp_row = '0;
        for (int j = 0; j < REF_W; j++) begin
            exp_row[j*BIT_DEPTH +: BIT_DEPTH] = pix(wx0 + j, wy);
        end
    endfunction

    // Fetch-stage model: answers each request one cycle later; optional noise valids.
    logic       pend_v;
    logic [2:0] pend_xx, pend_yy;
    logic [3:0] pend_zz;
    initial begin
        fme.fme_ld_valid_i = 1'b0;
        fme.fme_lddata_i   = '0;
        pend_v = 1'b0;
        pend_xx = '0;
        pend_yy = '0;
        pend_zz = '0;
        forever begin
            @(negedge clk);
            pend_v  = fme.fme_ld_en_o;
            pend_xx = fme.fme_sw_xx_o;
            pend_yy = fme.fme_sw_yy_o;
            pend_zz = fme.fme_sw_zz_o;
            @(posedge clk);
            #1;
            if (pend_v) begin
                fme.fme_ld_valid_i = 1'b1;
                fme.fme_lddata_i   = seg_of(pend_xx, pend_yy, pend_zz);
            end else if (noise_en) begin
                fme.fme_ld_valid_i = 1'b1;
                fme.fme_lddata_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                fme.fme_ld_valid_i = 1'b0;
                fme.fme_lddata_i   = '0;
            end
        end
    end

    // Monitor: pops the expected queues whenever the DUT presents an event.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (fme.fme_ld_en_o) begin
                if (exp_req_q.size() == 0) flag("req_extra");
                else chk("req_xyz", 256'({fme.fme_sw_xx_o, fme.fme_sw_yy_o, fme.fme_sw_zz_o}),
                         256'(exp_req_q.pop_front()));
            end
            if (fme.ref_wr_en_o) begin
                if (exp_wr_q.size() == 0) flag("wr_extra");
                else chk("wr_row", 256'({fme.ref_wr_addr_o, fme.ref_wr_data_o}),
                         256'(exp_wr_q.pop_front()));
            end
            if (done_o) begin
                if (exp_done_q.size() == 0) flag("done_extra");
                else begin
                    chk("done_cycle", 256'(cyc), 256'(exp_done_q.pop_front()));
                    chk("ld_done_eq", 256'(fme.fme_ld_done_o), 256'(1));
                end
            end
        end
    end

    task automatic push_exp(input int c0, input int off, input int wy0);
        int s;
        logic [2:0] xx;
        for (int r = 0; r < REF_W; r++) begin
            for (int k = 0; k < SEGS_PER_ROW; k++) begin
                xx = 3'(c0 - 1 + k);
                s  = wy0 + r;
                exp_req_q.push_back({xx, 3'(s / 16), 4'(s % 16)});
            end
            exp_wr_q.push_back({5'(r), exp_row(c0 * MB_WIDTH + off, wy0 + r)});
        end
    endtask

    task automatic run_mb(input vec_t v, input logic [7:0] mbx, input logic [7:0] mby);
        int c_st;
        bit seen;
        seen = 1'b0;
        push_exp(v.c0, v.off, v.wy0);
        noise_en = v.noise;
        @(posedge clk);
        #1;
        c_st = cyc;
        exp_done_q.push_back(32'(c_st + 75));
        start_i = 1'b1;
        mb_x_i  = mbx;
        mb_y_i  = mby;
        mv_x_i  = v.mvx;
        mv_y_i  = v.mvy;
        for (int n = 1; n <= 120 && !seen; n++) begin
            @(posedge clk);
            #1;
            start_i = (v.stray != 0 && n == v.stray);
            if (start_i) begin
                mb_x_i = ~mbx;
                mb_y_i = ~mby;
                mv_x_i = 7'h00;
                mv_y_i = 6'h00;
            end
            @(negedge clk);
            if (n == 1) begin
                chk("ld_start", 256'(fme.fme_ld_start_o), 256'(1));
                chk("ld_en_in_start", 256'(fme.fme_ld_en_o), 256'(0));
                chk("busy_start", 256'(busy_o), 256'(1));
                chk("mv_clip", 256'(mv_clip_o), 256'(v.clip));
                chk("state_start", 256'(fme.dbg_state), 256'(ST_START));
            end
            if (n == 2) begin
                chk("first_req", 256'({fme.fme_sw_xx_o, fme.fme_sw_yy_o, fme.fme_sw_zz_o}),
                    256'({v.fxx, v.fyy, v.fzz}));
                chk("ld_start_low", 256'(fme.fme_ld_start_o), 256'(0));
            end
            if (done_o) begin
                seen = 1'b1;
                chk("mb_xy_stable", 256'({fme.fme_mb_x_o, fme.fme_mb_y_o}), 256'({mbx, mby}));
                chk("busy_at_done", 256'(busy_o), 256'(1));
            end
        end
        chk("done_seen", 256'(seen), 256'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("busy_after", 256'(busy_o), 256'(0));
        chk("req_left", 256'(exp_req_q.size()), 256'(0));
        chk("wr_left", 256'(exp_wr_q.size()), 256'(0));
        chk("done_left", 256'(exp_done_q.size()), 256'(0));
        noise_en = 1'b0;
    endtask

    initial begin
        // mv fields are two's complement: 7'h64=-28, 6'h34=-12, 6'h2C=-20, 7'h7B=-5.
        vecs[0] = '{7'h00, 6'h00, 1, 12, 12, 1'b0, 3'd0, 3'd0, 4'd12, 0, 1'b0};
        vecs[1] = '{7'h64, 6'h34, 0, 0, 0, 1'b0, 3'b111, 3'd0, 4'd0, 0, 1'b0};
        vecs[2] = '{7'h13, 6'h0C, 2, 15, 24, 1'b0, 3'd1, 3'd1, 4'd8, 0, 1'b0};
        vecs[3] = '{7'h28, 6'h2C, 2, 15, 0, 1'b1, 3'd1, 3'd0, 4'd0, 0, 1'b0};
        vecs[4] = '{7'h7B, 6'h03, 1, 7, 15, 1'b0, 3'd0, 3'd0, 4'd15, 20, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 256'(busy_o), 256'(0));
        chk("rst_done", 256'({done_o, fme.fme_ld_done_o}), 256'(0));
        chk("rst_clip", 256'(mv_clip_o), 256'(0));
        chk("rst_ld", 256'({fme.fme_ld_start_o, fme.fme_ld_en_o}), 256'(0));
        chk("rst_wr", 256'({fme.ref_wr_en_o, fme.ref_wr_addr_o, fme.ref_wr_data_o}), 256'(0));
        chk("rst_mb", 256'({fme.fme_mb_x_o, fme.fme_mb_y_o}), 256'(0));
        chk("rst_state", 256'(fme.dbg_state), 256'(ST_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_mb(vecs[v], 8'(8'h10 + v), 8'(8'h20 + v));
        end

        // Abort: MV (3,-7) gives c0=1, off=15, wy0=5; reset hits at cycle 30.
        push_exp(1, 15, 5);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        mb_x_i  = 8'h33;
        mb_y_i  = 8'h44;
        mv_x_i  = 7'h03;
        mv_y_i  = 6'h39;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 256'(busy_o), 256'(0));
        chk("abort_done", 256'(done_o), 256'(0));
        chk("abort_ld", 256'({fme.fme_ld_start_o, fme.fme_ld_en_o}), 256'(0));
        chk("abort_win", 256'({fme.fme_sw_xx_o, fme.fme_sw_yy_o, fme.fme_sw_zz_o}), 256'(0));
        chk("abort_wr", 256'({fme.ref_wr_en_o, fme.ref_wr_addr_o}), 256'(0));
        chk("abort_mb", 256'({fme.fme_mb_x_o, fme.fme_mb_y_o}), 256'(0));
        chk("abort_state", 256'(fme.dbg_state), 256'(ST_IDLE));
        chk("abort_req_left", 256'(exp_req_q.size()), 256'(44));
        chk("abort_wr_left", 256'(exp_wr_q.size()), 256'(15));
        exp_req_q.delete();
        exp_wr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle", 256'(busy_o), 256'(0));

        run_mb(vecs[0], 8'h55, 8'h66);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fme_ref_loader.md
Name: fme_ref_loader

Overview:
- Load sequencer directly upstream of the FME fetch stage.
- On each macroblock, takes the IME integer best MV and issues the row-by-row search-window load requests (start / enable / xx / yy / zz / done) to the fetch stage.
- Captures the returned 16-pixel row segments, aligns them, and writes a 24x24 reference patch (MB plus 4-pixel border for 6-tap interpolation) into the FME reference buffer, one row per write.

Parameters:
BIT_DEPTH, 8, bits per pixel
MB_WIDTH, 16, pixels per fetched segment
PAD, 4, border pixels each side; REF_W = MB_WIDTH+2*PAD = 24

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  one-cycle MB start pulse
mb_x_i  in  8  current MB x (latched at accepted start)
mb_y_i  in  8  current MB y (latched at accepted start)
mv_x_i  in  7  signed integer MV x, pixels
mv_y_i  in  6  signed integer MV y, pixels
busy_o  out  1  high from accepted start until done_o inclusive
done_o  out  1  one-cycle pulse when the patch is fully written
mv_clip_o  out  1  latched at accept: the MV was clipped
fme_ld_start_o  out  1  load-start pulse to fetch stage
fme_ld_en_o  out  1  row-segment read request
fme_ld_done_o  out  1  equals done_o
fme_mb_x_o  out  8  latched mb_x
fme_mb_y_o  out  8  latched mb_y
fme_sw_xx_o  out  3  signed window column, -1..3
fme_sw_yy_o  out  3  window MB row, 0..2
fme_sw_zz_o  out  4  line within MB row
fme_lddata_i  in  MB_WIDTH*BIT_DEPTH  returned segment; pixel i at bits [i*BIT_DEPTH +: BIT_DEPTH]
fme_ld_valid_i  in  1  data valid, exactly 1 cycle after fme_ld_en_o
ref_wr_en_o  out  1  reference-buffer row write
ref_wr_addr_o  out  5  row 0..23
ref_wr_data_o  out  REF_W*BIT_DEPTH  aligned row; pixel 0 at LSB

Behaviour:
- Reset: every output is 0; FSM in IDLE; all counters cleared. Reset asserted mid-operation aborts the load with no done_o.
- Window coordinates:
  - The window is 5 columns x 3 MB rows.
  - Column index c = xx+1.
  - The current MB sits at wx = 32, wy = 16.
- Clipping at accept:
  - mv_x is clipped to [-28, 19]; mv_y is clipped to [-12, 12].
  - mv_clip_o = 1 if either component changed.
- Patch origin:
  - wx0 = 28 + mv_x, range 0..47.
  - c0 = wx0 >> 4, range 0..2.
  - off = wx0 & 15.
  - wy0 = 12 + mv_y, range 0..24.
- FSM:
  - IDLE: start_i accepted only here; latch inputs and go to START. start_i is ignored in every other state.
  - START: 1 cycle; fme_ld_start_o = 1, fme_ld_en_o = 0.
  - REQ: 72 consecutive cycles with fme_ld_en_o = 1.
    - Row r runs 0..23 (outer loop); k runs 0..2 (inner loop).
    - xx = c0 - 1 + k.
    - yy = (wy0 + r) >> 4.
    - zz = (wy0 + r) & 15.
    - Go to DRAIN after r = 23, k = 2.
  - DRAIN: wait for the last fme_ld_valid_i.
  - DONE: 1 cycle; done_o = fme_ld_done_o = 1; return to IDLE.
- Capture:
  - A 2-bit k tag is delayed one cycle alongside the request.
  - The valid segment is placed into a 48-pixel row register at slot k.
  - On the k = 2 valid, in the same cycle:
    - ref_wr_en_o = 1
    - ref_wr_addr_o = row count
    - ref_wr_data_o = row48 pixels [off .. off+23]
  - The write is driven combinationally from the register plus the incoming segment, so there is no extra cycle.
- Timing (start_i accepted at cycle 0):
  - fme_ld_start_o at cycle 1.
  - fme_ld_en_o at cycles 2..73.
  - Row writes at cycles 5, 8, .., 74.
  - done_o at cycle 75.
  - busy_o high for cycles 1..75.
- fme_ld_valid_i seen outside the expected slots is ignored.
- fme_mb_x_o / fme_mb_y_o stay stable from START through DONE.

Decomposition:
- Shared package (enc_defines): BIT_DEPTH, MB_WIDTH, PAD, window column/row counts (5, 3), MV clip bounds, REF_W.
- One sub-module, fme_ref_align: combinational 48-to-24 pixel selector taking the row register, the incoming segment and off.
- FSM, counters and capture stay in the top module.

Test Plan:
- MV (0,0):
  - c0 = 1, off = 12, so xx sequence 0,1,2; first request yy = 0, zz = 12; row 4 request yy = 1, zz = 0.
  - Row 0 data = window pixels wx 28..51.
  - done_o at cycle 75.
- MV (-28,-12):
  - xx = -1,0,1, off = 0, first yy = 0, zz = 0.
  - Row 23 written at ref_wr_addr_o = 23; mv_clip_o = 0.
- MV (19,12):
  - c0 = 2, off = 15, xx = 1,2,3; first request yy = 1, zz = 8; last request yy = 2, zz = 15.
  - Aligned pixels wx 47..70 are correct.
- MV (40,-20):
  - Clipped to (19,-12); mv_clip_o = 1.
  - Request stream matches the (19,-12) golden model.
- start_i pulsed during REQ: ignored; exactly 72 requests, 24 writes and 1 done_o.
- rst_n low at cycle 30:
  - All outputs 0 next edge; no done_o.
  - A new start after release completes normally.
